mux_cmp_pipe: RTL and testbench
===============================

# mux_cmp_pipe

Parametrised, pipelined operand-select and magnitude-compare unit. It picks one A operand and one B operand from NCH input channels, compares them under a run-time mode (unsigned or signed, > or ≥), and returns a registered 1-bit result over a valid/ready handshake. It also keeps a saturating count of "true" results. It is the sequential, generalised successor of the team's fixed 4-source combinational select-and-compare cone, and sits between the operand bus and the decision logic that consumes the compare flag.

## Interface
Parameters:
- W, 8, operand width in bits (≥2)
- NCH, 4, channels per operand bus (power of two, ≥2)
- SW, $clog2(NCH), select width (derived; do not override)
- CNT_W, 16, width of the result counter (≥2)

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand set valid
- in_ready  out  1  unit can accept an operand set
- a_bus  in  NCH*W  A channels; channel k is a_bus[k*W +: W]
- b_bus  in  NCH*W  B channels, same packing as a_bus
- a_sel  in  SW  A channel index
- b_sel  in  SW  B channel index
- mode  in  2  compare mode: 00 unsigned A>B; 01 unsigned A≥B; 10 signed A>B; 11 signed A≥B (two's complement)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_res  out  1  compare result
- res_cnt  out  CNT_W  saturating count of accepted results with out_res=1
- cnt_clr  in  1  synchronous clear of res_cnt
- out_eq  out  1  A==B for the same operand set; present only with MUXCMP_EQ_FLAG_EN

## Operation
- Stage S1: on accept (in_valid && in_ready), register a_bus[a_sel], b_bus[b_sel] and mode. Set s1_v.
- Stage S2: compute the compare from the S1 registers and register it into out_res (and out_eq). Set s2_v. out_valid = s2_v.
- Compare rule: signed modes compare {A[W-1]^1, A[W-2:0]} against {B[W-1]^1, B[W-2:0]} unsigned. No arithmetic overflow is possible and no widening is needed.
- Flow control (per-stage, bubble-collapsing):
  - s2 advances when !s2_v || out_ready.
  - s1 advances when !s1_v || s2 advances.
  - in_ready = !rst && (!s1_v || s2 advances). This path is combinational from out_ready, with no combinational path from in_valid.
- While out_valid=1 && out_ready=0, out_res and out_eq hold stable.
- res_cnt increments on (out_valid && out_ready && out_res) and saturates at 2^CNT_W−1.
- cnt_clr has priority over increment: when both occur in the same cycle, res_cnt goes to 0.
- Selects and mode are sampled only on accept. Changes at other times have no effect.

## Timing
- Reset values: out_valid=0, out_res=0, out_eq=0, res_cnt=0, s1_v=0, in_ready=0 while rst=1. in_ready=1 in the first cycle after rst deasserts.
- Latency: accept at edge N → out_valid=1 after edge N+1. Throughput is 1 result/cycle with out_ready held high.
- Back-pressure: with out_ready=0, the pipe fills two entries and then in_ready=0. The first cycle with out_ready=1 both releases S2 and refills it from S1, so no bubble is inserted.
- Simultaneous accept and output handshake in one cycle is legal and required to sustain full rate.
- rst mid-operation: all in-flight entries are dropped without being presented, and res_cnt clears. No partial handshake completes in the reset cycle.
- An out-of-range select cannot occur because NCH is a power of two.

## Configuration
- MUXCMP_EQ_FLAG_EN defined:
  - adds the out_eq port and its equality comparator in S2, pipelined with out_res;
  - reset value of out_eq is 0.
- Not defined:
  - port and logic absent;
  - all other behaviour identical.

## Test plan
- Reset then single op. Set W=8, NCH=4, a_bus ch2=0x90, b_bus ch1=0x10, a_sel=2, b_sel=1. Check per mode:
  - mode=00: out_res=1 two cycles after accept, res_cnt=1.
  - mode=10 (0x90 = −112 signed): out_res=0, res_cnt unchanged.
- Equality boundary: A=B=0x7F.
  - mode 00 → 0; mode 01 → 1.
  - With MUXCMP_EQ_FLAG_EN, out_eq=1 in both cases.
- Back-pressure:
  - Stream 5 ops with out_ready=0. Check in_ready drops after 2 accepts, and out_res holds stable.
  - Raise out_ready. Check all 5 results emerge in order with no gaps and no duplicates.
- Counter saturation and clear:
  - With CNT_W=2, 5 true results → res_cnt=3.
  - cnt_clr asserted in the same cycle as a true handshake → res_cnt=0.
- Mid-operation reset: assert rst with 2 entries in flight. Check:
  - out_valid=0 the next cycle and res_cnt=0;
  - no stale result appears after rst releases;
  - the first new op has latency 2.
- Full-rate random: 1000 ops with random selects, modes, data and out_ready. Results match a reference model, and res_cnt equals the model's saturated count.

Source files
------------

// File: rtl/mux_cmp_pipe_if.sv
// rtl/mux_cmp_pipe_if.sv - operand/result handshake bundle for mux_cmp_pipe
// out_eq is present only when MUXCMP_EQ_FLAG_EN is defined.
interface mux_cmp_pipe_if #(
    parameter int W     = 8,
    parameter int NCH   = 4,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(NCH);

    logic                 in_valid;
    logic                 in_ready;
    logic [NCH*W-1:0]     a_bus;
    logic [NCH*W-1:0]     b_bus;
    logic [SW-1:0]        a_sel;
    logic [SW-1:0]        b_sel;
    logic [1:0]           mode;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_res;
    logic [CNT_W-1:0]     res_cnt;
    logic                 cnt_clr;
`ifdef MUXCMP_EQ_FLAG_EN
    logic                 out_eq;

    modport master (
        output in_valid, a_bus, b_bus, a_sel, b_sel, mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_res, res_cnt, out_eq
    );
    modport slave (
        input  in_valid, a_bus, b_bus, a_sel, b_sel, mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_res, res_cnt, out_eq
    );
`else
    modport master (
        output in_valid, a_bus, b_bus, a_sel, b_sel, mode, out_ready, cnt_clr,
        input  in_ready, out_valid, out_res, res_cnt
    );
    modport slave (
        input  in_valid, a_bus, b_bus, a_sel, b_sel, mode, out_ready, cnt_clr,
        output in_ready, out_valid, out_res, res_cnt
    );
`endif
endinterface

// File: rtl/mux_cmp_pipe.sv
// rtl/mux_cmp_pipe.sv - two-stage operand select and magnitude compare with saturating true count
// Optional equality flag: define MUXCMP_EQ_FLAG_EN.
module mux_cmp_pipe #(
    parameter int W     = 8,
    parameter int NCH   = 4,
    parameter int SW    = $clog2(NCH),
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    mux_cmp_pipe_if.slave s_if
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_s1_v;
    logic [W-1:0]     r_s1_a;
    logic [W-1:0]     r_s1_b;
    logic [1:0]       r_s1_mode;
    logic             r_s2_v;
    logic             r_res;
    logic [CNT_W-1:0] r_cnt;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic             w_out_hs;
    logic [W-1:0]     w_a_mux;
    logic [W-1:0]     w_b_mux;
    logic [W-1:0]     w_a_key;
    logic [W-1:0]     w_b_key;
    logic             w_gt;
    logic             w_eq;
    logic             w_res;

    // Each stage may move whenever the one downstream frees up in the same cycle.
    assign w_s2_adv = !r_s2_v || s_if.out_ready;
    assign w_s1_adv = !r_s1_v || w_s2_adv;
    assign w_accept = s_if.in_valid && s_if.in_ready;
    assign w_out_hs = r_s2_v && s_if.out_ready;

    assign s_if.in_ready  = !rst && w_s1_adv;
    assign s_if.out_valid = r_s2_v;
    assign s_if.out_res   = r_res;
    assign s_if.res_cnt   = r_cnt;

    always_comb begin
        w_a_mux = '0;
        w_b_mux = '0;
        for (int k = 0; k < NCH; k++) begin
            if (s_if.a_sel == SW'(k)) w_a_mux = s_if.a_bus[k*W +: W];
            if (s_if.b_sel == SW'(k)) w_b_mux = s_if.b_bus[k*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s1_mode <= 2'b00;
        end else begin
            if (w_s1_adv) r_s1_v <= w_accept;
            if (w_accept) begin
                r_s1_a    <= w_a_mux;
                r_s1_b    <= w_b_mux;
                r_s1_mode <= s_if.mode;
            end
        end
    end

    // Flipping the sign bit maps two's complement order onto unsigned order.
    assign w_a_key = {r_s1_a[W-1] ^ r_s1_mode[1], r_s1_a[W-2:0]};
    assign w_b_key = {r_s1_b[W-1] ^ r_s1_mode[1], r_s1_b[W-2:0]};
    assign w_gt    = w_a_key > w_b_key;
    assign w_eq    = r_s1_a == r_s1_b;
    assign w_res   = w_gt || (r_s1_mode[0] && w_eq);

`ifdef MUXCMP_EQ_FLAG_EN
    logic r_eq;
    assign s_if.out_eq = r_eq;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v <= 1'b0;
            r_res  <= 1'b0;
`ifdef MUXCMP_EQ_FLAG_EN
            r_eq   <= 1'b0;
`endif
        end else if (w_s2_adv) begin
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_res <= w_res;
`ifdef MUXCMP_EQ_FLAG_EN
                r_eq  <= w_eq;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || s_if.cnt_clr) begin
            r_cnt <= '0;
        end else if (w_out_hs && r_res && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_mux_cmp_pipe.sv
// tb/tb_mux_cmp_pipe.sv - directed-table and scoreboard bench for mux_cmp_pipe (W=8, NCH=4, CNT_W=2)
module tb_mux_cmp_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_cmp_pipe_if #(.W(8), .NCH(4), .CNT_W(2)) bus ();
    mux_cmp_pipe #(.W(8), .NCH(4), .CNT_W(2)) dut (.clk(clk), .rst(rst), .s_if(bus));

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] as;
        logic [1:0] bs;
        logic [1:0] mode;
        logic       res;
        logic       eq;
        logic [1:0] cnt;
    } vec_t;

    vec_t       tbl [10];
    logic [1:0] q [$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [1:0] model_cnt;
    logic [1:0] front;
    logic [7:0] bp_a [5];
    logic [7:0] bp_b [5];
    int         idx;
    int         sent;
    int         cyc;
    logic       held;
    logic       held_set;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] fill(input logic [7:0] v, input logic [1:0] sel);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = (k == int'(sel)) ? v : ~v;
        return r;
    endfunction

    // Reference compare: {result, equal}, using native signed arithmetic.
    function automatic logic [1:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        logic gt;
        logic eq;
        gt = m[1] ? ($signed(a) > $signed(b)) : (a > b);
        eq = (a == b);
        return {m[0] ? (gt || eq) : gt, eq};
    endfunction

    function automatic logic [1:0] model_bus();
        return model(bus.a_bus[bus.a_sel*8 +: 8], bus.b_bus[bus.b_sel*8 +: 8], bus.mode);
    endfunction

    task automatic drive_op(input logic v, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] as, input logic [1:0] bs, input logic [1:0] m);
        bus.in_valid = v;
        bus.a_bus    = fill(a, as);
        bus.b_bus    = fill(b, bs);
        bus.a_sel    = as;
        bus.b_sel    = bs;
        bus.mode     = m;
    endtask

    task automatic check_out(input string name, input logic [1:0] exp);
        check({name, "_res"}, {31'd0, bus.out_res}, {31'd0, exp[1]});
`ifdef MUXCMP_EQ_FLAG_EN
        check({name, "_eq"}, {31'd0, bus.out_eq}, {31'd0, exp[0]});
`endif
    endtask

    initial begin
        tbl[0] = '{8'h90, 8'h10, 2'd2, 2'd1, 2'b00, 1'b1, 1'b0, 2'd1};
        tbl[1] = '{8'h90, 8'h10, 2'd2, 2'd1, 2'b10, 1'b0, 1'b0, 2'd1};
        tbl[2] = '{8'h7F, 8'h7F, 2'd0, 2'd3, 2'b00, 1'b0, 1'b1, 2'd1};
        tbl[3] = '{8'h7F, 8'h7F, 2'd1, 2'd1, 2'b01, 1'b1, 1'b1, 2'd2};
        tbl[4] = '{8'h7F, 8'h80, 2'd3, 2'd0, 2'b10, 1'b1, 1'b0, 2'd3};
        tbl[5] = '{8'h7F, 8'h80, 2'd3, 2'd0, 2'b00, 1'b0, 1'b0, 2'd3};
        tbl[6] = '{8'h80, 8'h80, 2'd2, 2'd2, 2'b11, 1'b1, 1'b1, 2'd3};
        tbl[7] = '{8'hFF, 8'h00, 2'd0, 2'd1, 2'b10, 1'b0, 1'b0, 2'd3};
        tbl[8] = '{8'hFF, 8'h00, 2'd0, 2'd1, 2'b00, 1'b1, 1'b0, 2'd3};
        tbl[9] = '{8'h01, 8'hFF, 2'd1, 2'd2, 2'b11, 1'b1, 1'b0, 2'd3};
        bp_a = '{8'h05, 8'h03, 8'h09, 8'h01, 8'h08};
        bp_b = '{8'h03, 8'h05, 8'h01, 8'h09, 8'h02};

        drive_op(1'b0, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00);
        bus.out_ready = 1'b1;
        bus.cnt_clr   = 1'b0;

        // Reset state
        rst = 1'b1;
        bus.in_valid = 1'b1;
        step();
        step();
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_out_res", {31'd0, bus.out_res}, 32'd0);
        check("rst_res_cnt", {30'd0, bus.res_cnt}, 32'd0);
`ifdef MUXCMP_EQ_FLAG_EN
        check("rst_out_eq", {31'd0, bus.out_eq}, 32'd0);
`endif
        bus.in_valid = 1'b0;
        rst = 1'b0;
        settle();
        check("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();

        // Directed single ops, one at a time, out_ready held high
        for (int i = 0; i < 10; i++) begin
            drive_op(1'b1, tbl[i].a, tbl[i].b, tbl[i].as, tbl[i].bs, tbl[i].mode);
            settle();
            check($sformatf("row%0d_in_ready", i), {31'd0, bus.in_ready}, 32'd1);
            step();
            drive_op(1'b0, ~tbl[i].b, ~tbl[i].a, ~tbl[i].as, ~tbl[i].bs, ~tbl[i].mode);
            settle();
            check($sformatf("row%0d_lat1", i), {31'd0, bus.out_valid}, 32'd0);
            step();
            check($sformatf("row%0d_valid", i), {31'd0, bus.out_valid}, 32'd1);
            check_out($sformatf("row%0d", i), {tbl[i].res, tbl[i].eq});
            step();
            check($sformatf("row%0d_cnt", i), {30'd0, bus.res_cnt}, {30'd0, tbl[i].cnt});
            check($sformatf("row%0d_drain", i), {31'd0, bus.out_valid}, 32'd0);
        end

        // Clear wins over a simultaneous true handshake
        drive_op(1'b1, 8'h05, 8'h03, 2'd0, 2'd0, 2'b00);
        step();
        bus.in_valid = 1'b0;
        step();
        check("clr_valid", {31'd0, bus.out_valid}, 32'd1);
        check("clr_res", {31'd0, bus.out_res}, 32'd1);
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        check("clr_cnt", {30'd0, bus.res_cnt}, 32'd0);

        // Back-pressure: fill with out_ready low, then drain at full rate
        bus.out_ready = 1'b0;
        idx = 0;
        held_set = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) drive_op(1'b1, bp_a[idx], bp_b[idx], 2'd0, 2'd0, 2'b00);
            settle();
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_bus());
                idx++;
            end
            if (bus.out_valid) begin
                if (!held_set) begin
                    held = bus.out_res;
                    held_set = 1'b1;
                end else begin
                    check("bp_hold", {31'd0, bus.out_res}, {31'd0, held});
                end
            end
            step();
        end
        check("bp_accepts", idx, 32'd2);
        check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
        check("bp_held_first", {31'd0, held}, 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) drive_op(1'b1, bp_a[idx], bp_b[idx], 2'd0, 2'd0, 2'b00);
            else bus.in_valid = 1'b0;
            settle();
            check($sformatf("bp_no_gap%0d", c), {31'd0, bus.out_valid}, 32'd1);
            if (q.size() > 0) begin
                front = q.pop_front();
                check_out($sformatf("bp_out%0d", c), front);
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_bus());
                idx++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        settle();
        check("bp_empty", {31'd0, bus.out_valid}, 32'd0);
        check("bp_queue", q.size(), 32'd0);
        check("bp_cnt", {30'd0, bus.res_cnt}, 32'd3);

        // Reset with two entries in flight
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive_op(1'b1, 8'hF0, 8'h01, 2'd1, 2'd2, 2'b00);
            step();
        end
        check("mr_full", {31'd0, bus.in_ready}, 32'd0);
        rst = 1'b1;
        bus.out_ready = 1'b1;
        settle();
        check("mr_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        check("mr_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("mr_cnt", {30'd0, bus.res_cnt}, 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("mr_no_stale%0d", c), {31'd0, bus.out_valid}, 32'd0);
        end
        drive_op(1'b1, 8'h02, 8'h81, 2'd3, 2'd0, 2'b10);
        settle();
        check("mr_new_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        settle();
        check("mr_new_lat1", {31'd0, bus.out_valid}, 32'd0);
        step();
        check("mr_new_lat2", {31'd0, bus.out_valid}, 32'd1);
        check_out("mr_new", 2'b10);
        step();
        check("mr_new_cnt", {30'd0, bus.res_cnt}, 32'd1);

        // Random traffic against the scoreboard
        bus.cnt_clr = 1'b1;
        step();
        bus.cnt_clr = 1'b0;
        model_cnt = 2'd0;
        sent = 0;
        cyc = 0;
        q.delete();
        while ((sent < 1000 || q.size() > 0) && cyc < 20000) begin
            bus.in_valid  = (sent < 1000) && ($urandom_range(3) != 0);
            bus.a_bus     = $urandom();
            bus.b_bus     = $urandom();
            bus.a_sel     = 2'($urandom_range(3));
            bus.b_sel     = 2'($urandom_range(3));
            bus.mode      = 2'($urandom_range(3));
            bus.out_ready = ($urandom_range(3) != 0);
            bus.cnt_clr   = ($urandom_range(31) == 0);
            settle();
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    check("rand_spurious", {31'd0, bus.out_valid}, 32'd0);
                end else begin
                    front = q.pop_front();
                    check_out("rand", front);
                    if (!bus.cnt_clr && front[1] && model_cnt != 2'd3) model_cnt = model_cnt + 2'd1;
                end
            end
            if (bus.cnt_clr) model_cnt = 2'd0;
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model_bus());
                sent++;
            end
            step();
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.cnt_clr  = 1'b0;
        check("rand_done", {31'd0, (sent == 1000 && q.size() == 0)}, 32'd1);
        check("rand_cnt", {30'd0, bus.res_cnt}, {30'd0, model_cnt});
        step();
        check("rand_idle", {31'd0, bus.out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
